// File: rtl/decimal_entry_to_signed.sv
// rtl/decimal_entry_to_signed.sv - BCD keystroke entry to signed 8-bit value
// Optional inactivity timeout: define ENTRY_TIMEOUT_EN.
module decimal_entry_to_signed #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digit_in,
    input  logic        digit_stb,
    input  logic        neg_stb,
    input  logic        enter_stb,
    input  logic        clear_stb,
    output logic [7:0]  val_out,
    output logic        val_valid,
    output logic        err,
    output logic        busy,
    output logic [11:0] entry_bcd,
    output logic        entry_neg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] bcd_q, bcd_d;
    logic        neg_q, neg_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [9:0]  mag_q, mag_d;
    logic [7:0]  val_q, val_d;
    logic        valid_q, valid_d;
    logic        acted;
    logic        timeout_hit;
    logic        in_range;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_q, tmo_d;

    assign timeout_hit = (state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = '0;
        if (state_d != ST_IDLE && !acted) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Negative entries may reach 128 because -128 is representable.
    assign in_range = neg_q ? (mag_q <= 10'd128) : (mag_q <= 10'd127);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            mag_q   <= '0;
            val_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            val_q   <= val_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        val_d   = val_q;
        valid_d = 1'b0;
        acted   = 1'b0;

        if (clear_stb || timeout_hit) begin
            acted   = clear_stb;
            state_d = ST_IDLE;
            bcd_d   = '0;
            neg_d   = 1'b0;
            cnt_d   = '0;
            mag_d   = '0;
        end else if (enter_stb) begin
            if (state_q == ST_ENTRY) begin
                acted = 1'b1;
                if (in_range) begin
                    val_d   = neg_q ? (8'd0 - mag_q[7:0]) : mag_q[7:0];
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                    bcd_d   = '0;
                    neg_d   = 1'b0;
                    cnt_d   = '0;
                    mag_d   = '0;
                end else begin
                    state_d = ST_ERROR;
                end
            end
        end else if (neg_stb) begin
            if (state_q != ST_ERROR) begin
                acted   = 1'b1;
                neg_d   = ~neg_q;
                state_d = ST_ENTRY;
            end
        end else if (digit_stb) begin
            if (state_q != ST_ERROR && digit_in <= 4'd9 && cnt_q < 2'd3) begin
                acted   = 1'b1;
                bcd_d   = {bcd_q[7:0], digit_in};
                mag_d   = mag_q * 10'd10 + {6'd0, digit_in};
                cnt_d   = cnt_q + 2'd1;
                state_d = ST_ENTRY;
            end
        end
    end

    always_comb begin
        val_out   = val_q;
        val_valid = valid_q;
        err       = (state_q == ST_ERROR);
        busy      = (state_q != ST_IDLE);
        entry_bcd = bcd_q;
        entry_neg = neg_q;
    end

endmodule

// File: tb/tb_decimal_entry_to_signed.sv
// tb/tb_decimal_entry_to_signed.sv - directed bench for decimal_entry_to_signed
module tb_decimal_entry_to_signed;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  digit_in = 4'd0;
    logic        digit_stb = 1'b0;
    logic        neg_stb = 1'b0;
    logic        enter_stb = 1'b0;
    logic        clear_stb = 1'b0;
    logic [7:0]  val_out;
    logic        val_valid;
    logic        err;
    logic        busy;
    logic [11:0] entry_bcd;
    logic        entry_neg;

    int checks = 0;
    int failures = 0;

    decimal_entry_to_signed #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .digit_in  (digit_in),
        .digit_stb (digit_stb),
        .neg_stb   (neg_stb),
        .enter_stb (enter_stb),
        .clear_stb (clear_stb),
        .val_out   (val_out),
        .val_valid (val_valid),
        .err       (err),
        .busy      (busy),
        .entry_bcd (entry_bcd),
        .entry_neg (entry_neg)
    );

    always #5 clk = ~clk;

    // Called at a negedge; applies strobes across one rising edge, returns at the next negedge.
    task automatic strobe(input logic d, input logic [3:0] dv, input logic n,
                          input logic e, input logic c);
        digit_stb = d;
        digit_in  = dv;
        neg_stb   = n;
        enter_stb = e;
        clear_stb = c;
        @(negedge clk);
        digit_stb = 1'b0;
        neg_stb   = 1'b0;
        enter_stb = 1'b0;
        clear_stb = 1'b0;
    endtask

    task automatic key(input logic [3:0] dv);
        strobe(1'b1, dv, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic key_neg();
        strobe(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic key_enter();
        strobe(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic key_clear();
        strobe(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        checks++;
        if ({val_out, val_valid, err, busy, entry_bcd, entry_neg} !== 24'h0) begin
            failures++;
            $display("FAIL reset_state: got val=%h vv=%b err=%b busy=%b bcd=%h neg=%b, want all zero",
                     val_out, val_valid, err, busy, entry_bcd, entry_neg);
        end
    endtask

    task automatic test_positive_max();
        key(4'd1); key(4'd2); key(4'd7);
        checks++;
        if (entry_bcd !== 12'h127 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pos_entry: got bcd=%h busy=%b, want 127 1", entry_bcd, busy);
        end
        key_enter();
        checks++;
        if (val_out !== 8'h7F || val_valid !== 1'b1 || entry_bcd !== 12'h000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL pos_commit: got val=%h vv=%b bcd=%h busy=%b, want 7f 1 000 0",
                     val_out, val_valid, entry_bcd, busy);
        end
        @(negedge clk);
        checks++;
        if (val_valid !== 1'b0 || val_out !== 8'h7F) begin
            failures++;
            $display("FAIL pulse_width: got vv=%b val=%h, want 0 7f", val_valid, val_out);
        end
    endtask

    task automatic test_negative();
        key_neg(); key(4'd1); key(4'd2); key(4'd8);
        checks++;
        if (entry_neg !== 1'b1 || entry_bcd !== 12'h128) begin
            failures++;
            $display("FAIL neg_entry: got neg=%b bcd=%h, want 1 128", entry_neg, entry_bcd);
        end
        key_enter();
        checks++;
        if (val_out !== 8'h80 || val_valid !== 1'b1 || entry_neg !== 1'b0) begin
            failures++;
            $display("FAIL neg_128: got val=%h vv=%b neg=%b, want 80 1 0", val_out, val_valid, entry_neg);
        end
        key_neg(); key(4'd5); key_enter();
        checks++;
        if (val_out !== 8'hFB || val_valid !== 1'b1) begin
            failures++;
            $display("FAIL neg_5: got val=%h vv=%b, want fb 1", val_out, val_valid);
        end
    endtask

    task automatic test_overflow();
        key(4'd1); key(4'd2); key(4'd8); key_enter();
        checks++;
        if (err !== 1'b1 || busy !== 1'b1 || val_out !== 8'hFB || val_valid !== 1'b0 ||
            entry_bcd !== 12'h128) begin
            failures++;
            $display("FAIL pos_128_err: got err=%b busy=%b val=%h vv=%b bcd=%h, want 1 1 fb 0 128",
                     err, busy, val_out, val_valid, entry_bcd);
        end
        key(4'd3); key_neg();
        checks++;
        if (entry_bcd !== 12'h128 || entry_neg !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL err_ignores: got bcd=%h neg=%b err=%b, want 128 0 1", entry_bcd, entry_neg, err);
        end
        key_clear();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || entry_bcd !== 12'h000 || val_out !== 8'hFB) begin
            failures++;
            $display("FAIL err_clear: got err=%b busy=%b bcd=%h val=%h, want 0 0 000 fb",
                     err, busy, entry_bcd, val_out);
        end
    endtask

    task automatic test_digit_limits();
        key(4'd9); key(4'd9); key(4'd9); key(4'd4);
        checks++;
        if (entry_bcd !== 12'h999) begin
            failures++;
            $display("FAIL fourth_digit: got bcd=%h, want 999", entry_bcd);
        end
        key_clear();
        key(4'd2); key(4'hB);
        checks++;
        if (entry_bcd !== 12'h002) begin
            failures++;
            $display("FAIL non_bcd_digit: got bcd=%h, want 002", entry_bcd);
        end
        key(4'd9); key(4'd9); key_enter();
        checks++;
        if (err !== 1'b1 || val_valid !== 1'b0 || entry_bcd !== 12'h299) begin
            failures++;
            $display("FAIL big_err: got err=%b vv=%b bcd=%h, want 1 0 299", err, val_valid, entry_bcd);
        end
        key_clear();
    endtask

    task automatic test_priority();
        key(4'd4); key(4'd2);
        strobe(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (val_valid !== 1'b0 || busy !== 1'b0 || entry_bcd !== 12'h000 || val_out !== 8'hFB) begin
            failures++;
            $display("FAIL enter_clear: got vv=%b busy=%b bcd=%h val=%h, want 0 0 000 fb",
                     val_valid, busy, entry_bcd, val_out);
        end
        strobe(1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
        checks++;
        if (entry_neg !== 1'b1 || entry_bcd !== 12'h000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL neg_over_digit: got neg=%b bcd=%h busy=%b, want 1 000 1",
                     entry_neg, entry_bcd, busy);
        end
        key_enter();
        checks++;
        if (val_out !== 8'h00 || val_valid !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL neg_zero: got val=%h vv=%b busy=%b, want 00 1 0", val_out, val_valid, busy);
        end
        key_enter();
        checks++;
        if (val_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_enter: got vv=%b busy=%b, want 0 0", val_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        key(4'd5); key(4'd0); key_enter();
        checks++;
        if (val_out !== 8'h32 || val_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_50: got val=%h vv=%b, want 32 1", val_out, val_valid);
        end
        key_neg(); key(4'd7); key_enter();
        checks++;
        if (val_out !== 8'hF9 || val_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_m7: got val=%h vv=%b, want f9 1", val_out, val_valid);
        end
    endtask

    task automatic test_reset_mid_entry();
        key_neg(); key(4'd3);
        rst = 1'b0;
        key_enter();
        rst = 1'b1;
        checks++;
        if ({val_out, val_valid, err, busy, entry_bcd, entry_neg} !== 24'h0) begin
            failures++;
            $display("FAIL reset_mid: got val=%h vv=%b err=%b busy=%b bcd=%h neg=%b, want all zero",
                     val_out, val_valid, err, busy, entry_bcd, entry_neg);
        end
    endtask

`ifdef ENTRY_TIMEOUT_EN
    task automatic test_timeout();
        key(4'd3);
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || entry_bcd !== 12'h003) begin
            failures++;
            $display("FAIL tmo_early: got busy=%b bcd=%h, want 1 003", busy, entry_bcd);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || entry_bcd !== 12'h000) begin
            failures++;
            $display("FAIL tmo_fire: got busy=%b bcd=%h, want 0 000", busy, entry_bcd);
        end
        key(4'd1);
        repeat (5) @(negedge clk);
        key(4'd2);
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || entry_bcd !== 12'h012) begin
            failures++;
            $display("FAIL tmo_restart: got busy=%b bcd=%h, want 1 012", busy, entry_bcd);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || entry_bcd !== 12'h000) begin
            failures++;
            $display("FAIL tmo_refire: got busy=%b bcd=%h, want 0 000", busy, entry_bcd);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_positive_max();
        test_negative();
        test_overflow();
        test_digit_limits();
        test_priority();
        test_back_to_back();
`ifdef ENTRY_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_entry();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decimal_entry_to_signed.md
# decimal_entry_to_signed

Sequential decimal-entry block that converts operator keystrokes (up to three BCD digits plus a sign toggle) into a signed 8-bit two's-complement value. It is the input-side counterpart of the signed-value-to-seven-segment display path: the accepted byte feeds the slots game logic (bet/credit adjust), and the in-progress BCD digits and sign are exported so the display path can echo the entry. Entry is validated against the signed range −128..127 before it is released.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: inactivity limit in clock cycles (used only with `ENTRY_TIMEOUT_EN`); must be ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `digit_in`  in  4  BCD digit, sampled when `digit_stb` = 1.
- `digit_stb`  in  1  one-cycle digit keystroke strobe.
- `neg_stb`  in  1  one-cycle sign-toggle strobe.
- `enter_stb`  in  1  one-cycle commit strobe.
- `clear_stb`  in  1  one-cycle abort/clear strobe.
- `val_out`  out  8  last accepted signed value; holds until the next accept.
- `val_valid`  out  1  one-cycle pulse when `val_out` updates.
- `err`  out  1  level, high while in ERROR.
- `busy`  out  1  high in ENTRY or ERROR.
- `entry_bcd`  out  12  {hundreds, tens, ones} of the digits typed so far, right-justified.
- `entry_neg`  out  1  current sign flag of the entry.

## Operation
- States: IDLE, ENTRY, ERROR.
- Reset (`rst` = 0 at a clock edge): state IDLE; `val_out` = 8'h00; `val_valid`, `err`, `busy`, `entry_neg` = 0; `entry_bcd` = 12'h000; digit count = 0; magnitude = 0.
- Strobe priority when several are high in one cycle: clear > enter > neg > digit. Only the highest-priority strobe acts; the others are dropped.
- Digit acceptance: a digit is accepted only if `digit_in` ≤ 9 and count < 3. Otherwise the keystroke is ignored silently, with no state change. An accepted digit shifts `entry_bcd` left 4 bits, inserts the digit, sets magnitude = magnitude×10 + digit (10-bit, max 999), increments the count, and moves IDLE→ENTRY.
- `neg_stb`: in IDLE or ENTRY, toggles `entry_neg`. In IDLE it also moves to ENTRY with count 0.
- `enter_stb` in ENTRY:
  - With count = 0, the result is 0.
  - In range means magnitude ≤ 127 with `entry_neg` = 0, or magnitude ≤ 128 with `entry_neg` = 1.
  - In range: `val_out` = `entry_neg` ? −magnitude (8-bit two's complement) : magnitude. Pulse `val_valid`, clear the entry (`entry_bcd`, `entry_neg`, count, magnitude), and return to IDLE.
  - Out of range: go to ERROR. `val_out` is unchanged and there is no pulse. The entry fields are held so the display keeps showing them.
  - Negative zero commits as 8'h00.
- `enter_stb` in IDLE: ignored.
- ERROR: digit, neg and enter strobes are ignored. `clear_stb` clears the entry and moves to IDLE.
- `clear_stb` in any state: clears the entry and moves to IDLE. `val_out` is never altered by clear.

## Timing
- All outputs are registered.
- A strobe sampled at edge N is reflected in the outputs after edge N (visible during cycle N+1).
- `val_valid` is high for exactly one cycle following the accepting edge, and `val_out` is already valid in that cycle.
- Back-to-back strobes on consecutive cycles are each processed; there is no minimum spacing.
- Reset asserted mid-entry or in ERROR discards the entry, applies the reset values above, and suppresses any pending `val_valid`.

## Configuration
- `ENTRY_TIMEOUT_EN` defined:
  - An inactivity counter runs while in ENTRY or ERROR. Any acted-on strobe (digit, neg, enter or clear) resets it to 0.
  - When it reaches `TIMEOUT_CYCLES`−1, the next edge behaves exactly as `clear_stb`: entry cleared, state IDLE.
  - The counter is held at 0 in IDLE.
- `ENTRY_TIMEOUT_EN` undefined:
  - No counter is built and `TIMEOUT_CYCLES` is unused.
  - Entry and ERROR persist indefinitely until a strobe or reset.

## Test plan
- Reset, then digits 1,2,7 and enter → `val_out` = 8'h7F, `val_valid` one cycle, `entry_bcd` = 12'h000, state IDLE.
- neg, digits 1,2,8, enter → `val_out` = 8'h80. Next entry neg, 5, enter → 8'hFB.
- Digits 1,2,8 (positive), enter → `err` = 1, `busy` = 1, `val_out` keeps its prior value, `entry_bcd` = 12'h128, no pulse. Digit 3 is ignored. Clear → IDLE, `err` = 0.
- Digits 9,9,9 then 4 → `entry_bcd` stays 12'h999 (fourth digit ignored). `digit_in` = 4'hB is ignored. Enter → ERROR.
- Simultaneous `enter_stb` and `clear_stb` with entry "42" → cleared, no `val_valid`. Neg then enter with count 0 → `val_out` = 8'h00 with a pulse.
- `ENTRY_TIMEOUT_EN` with `TIMEOUT_CYCLES` = 8:
  - Digit 3, then idle 8 cycles → IDLE, `entry_bcd` = 0.
  - A digit strobe at cycle 6 restarts the count, so there is no timeout until 8 cycles after that strobe.
  - `rst` = 0 mid-entry → all reset values applied.
